// File: rtl/store_write_buffer.sv
// Write-through store buffer: FIFO of pending word stores drained one at a time to main memory,
// with youngest-match forwarding to refill reads. Optional in-place coalescing under WB_COALESCE_EN.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_stall,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_fwd_hit,
  output logic [DATA_W-1:0] rd_fwd_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;

  logic              push, pop, latch;
  logic              coal_hit;
  logic [PW-1:0]     coal_idx;
  logic [PW-1:0]     fwd_idx;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0) && (state == IDLE);

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rd_fwd_hit  = 1'b0;
    rd_fwd_data = '0;
    fwd_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == rd_addr)) begin
        rd_fwd_hit  = 1'b1;
        rd_fwd_data = data_q[fwd_idx];
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic [PW-1:0] scan_idx;
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if (wr_valid && valid_q[scan_idx] && (addr_q[scan_idx] == wr_addr) &&
          !((state == BUSY) && (scan_idx == head))) begin
        coal_hit = 1'b1;
        coal_idx = scan_idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign push     = wr_valid && !coal_hit && !full;
  assign wr_stall = wr_valid && !(push || coal_hit);

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          latch    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A coalesce into the head on its latch edge must reach memory with the new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (latch) begin
      mem_write <= 1'b1;
      mem_addr  <= addr_q[head];
      mem_wdata <= (coal_hit && (coal_idx == head)) ? wr_data : data_q[head];
    end else if (pop) begin
      mem_write <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= wr_addr;
      data_q[tail] <= wr_data;
    end else if (coal_hit) begin
      data_q[coal_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random traffic,
// all checked against a queue-based model of the buffer.
module tb_store_write_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_stall;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_fwd_hit;
  logic [DATA_W-1:0] rd_fwd_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready = 1'b0;
  logic              empty;
  logic              full;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_stall(wr_stall),
    .rd_addr(rd_addr), .rd_fwd_hit(rd_fwd_hit), .rd_fwd_data(rd_fwd_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  bit                m_busy;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] drained_a[$];
  logic [DATA_W-1:0] drained_d[$];

  task automatic model_reset();
    mq.delete();
    m_busy = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic bit m_full();
    return mq.size() == DEPTH;
  endfunction

  function automatic int m_coal_idx();
    int r = -1;
`ifdef WB_COALESCE_EN
    if (wr_valid)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (!(m_busy && i == 0) && mq[i].a == wr_addr) begin
          r = i;
          break;
        end
`endif
    return r;
  endfunction

  function automatic bit exp_stall();
    return wr_valid && !(m_coal_idx() >= 0 || !m_full());
  endfunction

  task automatic model_edge();
    int   ci;
    bit   do_push;
    ent_t e;
    ci      = m_coal_idx();
    do_push = wr_valid && ci < 0 && !m_full();
    if (ci >= 0) begin
      e = mq[ci];
      e.d = wr_data;
      mq[ci] = e;
    end
    if (!m_busy) begin
      if (mq.size() > 0) begin
        m_busy = 1;
        m_addr = mq[0].a;
        m_data = mq[0].d;
      end
    end else if (mem_ready) begin
      m_busy = 0;
      void'(mq.pop_front());
    end
    if (do_push) begin
      e.a = wr_addr;
      e.d = wr_data;
      mq.push_back(e);
    end
  endtask

  // Inputs are already applied; checks combinational outputs, clocks once, checks registered outputs.
  task automatic cycle();
    bit                hit;
    logic [DATA_W-1:0] fd;
    #1;
    hit = 0;
    fd  = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == rd_addr) begin
        hit = 1;
        fd  = mq[i].d;
        break;
      end
    chk("wr_stall", wr_stall, exp_stall());
    chk("full", full, m_full());
    chk("fwd_hit", rd_fwd_hit, hit);
    chk("fwd_data", rd_fwd_data, fd);
    if (mem_write && mem_ready) begin
      drained_a.push_back(mem_addr);
      drained_d.push_back(mem_wdata);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_write", mem_write, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_data);
    end
    chk("empty", empty, mq.size() == 0 && !m_busy);
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1;
    wr_addr  = a;
    wr_data  = d;
    cycle();
    wr_valid = 0;
  endtask

  task automatic drain_all();
    mem_ready = 1;
    for (int i = 0; i < 40 && !(mq.size() == 0 && !m_busy); i++) cycle();
    mem_ready = 0;
    chk("drain_done", empty, 1);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(posedge clk);
    #1 reset = 0;

    // single store, held by memory for 3 cycles
    store(10'h010, 32'hDEADBEEF);
    chk("single_empty_drop", empty, 0);
    cycle();
    chk("single_mem_write", mem_write, 1);
    chk("single_mem_addr", mem_addr, 10'h010);
    chk("single_mem_wdata", mem_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1;
    cycle();
    mem_ready = 0;
    chk("single_done_write", mem_write, 0);
    chk("single_done_empty", empty, 1);

    // fill then stalled fifth store
    drained_a.delete();
    drained_d.delete();
    for (int i = 1; i <= 4; i++) store(ADDR_W'(i), DATA_W'(i * 16));
    chk("fill_full", full, 1);
    wr_valid = 1;
    wr_addr  = 10'd5;
    wr_data  = 32'h50;
    #1 chk("fill_stall", wr_stall, 1);
    cycle();
    mem_ready = 1;
    cycle();
    mem_ready = 0;
    #1 chk("fill_accept_after_pop", wr_stall, 0);
    cycle();
    wr_valid = 0;
    drain_all();
    chk("fill_drain_count", drained_a.size(), 5);
    for (int i = 0; i < 5 && i < drained_a.size(); i++)
      chk("fill_drain_order", drained_a[i], ADDR_W'(i + 1));

    // forwarding of duplicate addresses
    store(10'h020, 32'h11);
    store(10'h020, 32'h22);
    rd_addr = 10'h020;
    #1;
    chk("fwd_hit_dup", rd_fwd_hit, 1);
    chk("fwd_data_dup", rd_fwd_data, 32'h22);
    cycle();
    rd_addr = 10'h021;
    #1;
    chk("fwd_miss_hit", rd_fwd_hit, 0);
    chk("fwd_miss_data", rd_fwd_data, 0);
    cycle();
    drain_all();

    // pointer wrap: 10 stores with memory always ready
    begin
      int  n = 0;
      bit  done = 0;
      drained_a.delete();
      drained_d.delete();
      mem_ready = 1;
      for (int c = 0; c < 200 && !done; c++) begin
        bit acc;
        wr_valid = (n < 10);
        wr_addr  = ADDR_W'(10'h100 + n);
        wr_data  = DATA_W'(n);
        #0;
        acc = wr_valid && !exp_stall();
        cycle();
        if (acc) n++;
        if (n == 10 && mq.size() == 0 && !m_busy) done = 1;
      end
      wr_valid  = 0;
      mem_ready = 0;
      chk("wrap_finished", done, 1);
      chk("wrap_count", drained_a.size(), 10);
      for (int i = 0; i < 10 && i < drained_a.size(); i++)
        chk("wrap_order", drained_a[i], ADDR_W'(10'h100 + i));
    end

    // asynchronous reset while draining
    store(10'h040, 32'h1);
    store(10'h041, 32'h2);
    store(10'h042, 32'h3);
    cycle();
    chk("rst_mid_busy", mem_write, 1);
    reset = 1;
    #1;
    chk("rst_mid_write", mem_write, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_full", full, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;

`ifdef WB_COALESCE_EN
    drained_a.delete();
    drained_d.delete();
    store(10'h031, 32'hA);
    store(10'h030, 32'hB);
    store(10'h032, 32'hC);
    store(10'h033, 32'hD);
    chk("coal_full", full, 1);
    wr_valid = 1;
    wr_addr  = 10'h030;
    wr_data  = 32'h55;
    #1 chk("coal_stall", wr_stall, 0);
    cycle();
    wr_valid = 0;
    chk("coal_still_full", full, 1);
    drain_all();
    chk("coal_drain_count", drained_a.size(), 4);
    if (drained_a.size() >= 2) begin
      chk("coal_addr", drained_a[1], 10'h030);
      chk("coal_data", drained_d[1], 32'h55);
    end
`endif

    // random traffic over a small address space
    for (int c = 0; c < 500; c++) begin
      wr_valid  = $urandom_range(0, 1);
      wr_addr   = ADDR_W'($urandom_range(0, 7));
      wr_data   = $urandom;
      rd_addr   = ADDR_W'($urandom_range(0, 7));
      mem_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end
    wr_valid = 0;
    drain_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
